// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select and IF/ID pipeline register.
// Redirects win over stall for the PC; flush wins over stall for IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  next_pc_selector,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus_4,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic [6:0]  opcode,
  output logic        misaligned_fault
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  logic [31:0] r_pc;
  if_id_t      r_if_id;
  logic        r_fault;

  logic [31:0] w_pc_plus_4;
  logic        w_redirect;
  logic [31:0] w_target;

  assign w_pc_plus_4 = r_pc + 32'd4;
  assign w_redirect  = (next_pc_selector == 2'b01) ||
                       (next_pc_selector == 2'b10);

  always_comb begin
    w_target = branch_target;
    unique case (1'b1)
      (next_pc_selector == 2'b10): w_target = {jalr_target[31:1], 1'b0};
      default:                     w_target = branch_target;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= {w_target[31:2], 2'b00};
    end else if (!stall) begin
      r_pc <= w_pc_plus_4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_id.pc        <= 32'd0;
      r_if_id.pc_plus_4 <= 32'd0;
      r_if_id.instr     <= NOP_INSTR;
      r_if_id.valid     <= 1'b0;
    end else if (flush) begin
      r_if_id.instr <= NOP_INSTR;
      r_if_id.valid <= 1'b0;
    end else if (!stall) begin
      r_if_id.pc        <= r_pc;
      r_if_id.pc_plus_4 <= w_pc_plus_4;
      r_if_id.instr     <= imem_rdata;
      r_if_id.valid     <= 1'b1;
    end
  end

  // Sticky; reported only, fetch continues from the word-aligned target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (w_redirect && w_target[1]) begin
      r_fault <= 1'b1;
    end
  end

  assign imem_addr         = r_pc;
  assign if_id_pc          = r_if_id.pc;
  assign if_id_pc_plus_4   = r_if_id.pc_plus_4;
  assign if_id_instruction = r_if_id.instr;
  assign if_id_valid       = r_if_id.valid;
  assign opcode            = r_if_id.instr[6:0];
  assign misaligned_fault  = r_fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, flush,
// redirects, misalignment flag, PC wrap and asynchronous reset.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [1:0]  next_pc_selector;
  logic [31:0] branch_target;
  logic [31:0] jalr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus_4;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic [6:0]  opcode;
  logic        misaligned_fault;

  int n_cmp;
  int n_bad;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .flush            (flush),
    .next_pc_selector (next_pc_selector),
    .branch_target    (branch_target),
    .jalr_target      (jalr_target),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .if_id_pc         (if_id_pc),
    .if_id_pc_plus_4  (if_id_pc_plus_4),
    .if_id_instruction(if_id_instruction),
    .if_id_valid      (if_id_valid),
    .opcode           (opcode),
    .misaligned_fault (misaligned_fault)
  );

  // Instruction memory: word is a fixed pattern of its address.
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc,
                          input logic [31:0] ins, input logic v);
    chk({tag, ".pc"}, if_id_pc, pc);
    chk({tag, ".pc4"}, if_id_pc_plus_4, pc + 32'd4);
    chk({tag, ".ins"}, if_id_instruction, ins);
    chk({tag, ".op"}, {25'd0, opcode}, {25'd0, ins[6:0]});
    chk({tag, ".v"}, {31'd0, if_id_valid}, {31'd0, v});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    next_pc_selector = 2'b00;
    branch_target = 32'd0;
    jalr_target = 32'd0;

    #3;
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.pc", if_id_pc, 32'h0);
    chk("rst.pc4", if_id_pc_plus_4, 32'h0);
    chk("rst.ins", if_id_instruction, NOP);
    chk("rst.op", {25'd0, opcode}, 32'h13);
    chk("rst.v", {31'd0, if_id_valid}, 32'h0);
    chk("rst.flt", {31'd0, misaligned_fault}, 32'h0);

    @(negedge clk);
    rst = 1'b0;

    step();
    chk("seq1.addr", imem_addr, 32'h4);
    chk_ifid("seq1", 32'h0, 32'hDEAD_0000, 1'b1);
    step();
    chk("seq2.addr", imem_addr, 32'h8);
    chk_ifid("seq2", 32'h4, 32'hDEAD_0004, 1'b1);
    step();
    chk("seq3.addr", imem_addr, 32'hC);
    chk_ifid("seq3", 32'h8, 32'hDEAD_0008, 1'b1);
    step();
    chk("seq4.addr", imem_addr, 32'h10);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl.addr", imem_addr, 32'h10);
      chk_ifid("stl", 32'hC, 32'hDEAD_000C, 1'b1);
    end
    stall = 1'b0;
    step();
    chk("rel.addr", imem_addr, 32'h14);
    chk_ifid("rel", 32'h10, 32'hDEAD_0010, 1'b1);

    step();
    step();
    step();
    chk("at20.addr", imem_addr, 32'h20);

    next_pc_selector = 2'b01;
    branch_target = 32'h100;
    flush = 1'b1;
    step();
    chk("br.addr", imem_addr, 32'h100);
    chk_ifid("br", 32'h1C, NOP, 1'b0);
    chk("br.flt", {31'd0, misaligned_fault}, 32'h0);
    next_pc_selector = 2'b00;
    flush = 1'b0;
    step();
    chk("brt.addr", imem_addr, 32'h104);
    chk_ifid("brt", 32'h100, 32'hDEAD_0100, 1'b1);

    next_pc_selector = 2'b10;
    jalr_target = 32'h203;
    stall = 1'b1;
    step();
    chk("jr.addr", imem_addr, 32'h200);
    chk("jr.flt", {31'd0, misaligned_fault}, 32'h1);
    chk_ifid("jr", 32'h100, 32'hDEAD_0100, 1'b1);
    stall = 1'b0;
    next_pc_selector = 2'b01;
    branch_target = 32'h300;
    step();
    chk("br2.addr", imem_addr, 32'h300);
    chk("br2.flt", {31'd0, misaligned_fault}, 32'h1);
    chk_ifid("br2", 32'h200, 32'hDEAD_0200, 1'b1);

    next_pc_selector = 2'b11;
    step();
    chk("sel3.addr", imem_addr, 32'h304);

    next_pc_selector = 2'b01;
    branch_target = 32'hFFFF_FFFC;
    step();
    chk("top.addr", imem_addr, 32'hFFFF_FFFC);
    next_pc_selector = 2'b00;
    step();
    chk("wrap.addr", imem_addr, 32'h0);
    chk("wrap.pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap.pc4", if_id_pc_plus_4, 32'h0);
    chk("wrap.flt", {31'd0, misaligned_fault}, 32'h1);

    stall = 1'b1;
    flush = 1'b1;
    step();
    chk("fs.addr", imem_addr, 32'h0);
    chk("fs.pc", if_id_pc, 32'hFFFF_FFFC);
    chk("fs.ins", if_id_instruction, NOP);
    chk("fs.v", {31'd0, if_id_valid}, 32'h0);
    flush = 1'b0;
    step();
    chk("fs2.addr", imem_addr, 32'h0);
    next_pc_selector = 2'b10;
    jalr_target = 32'h400;
    #2;
    rst = 1'b1;
    #1;
    chk("arst.addr", imem_addr, 32'h0);
    chk("arst.pc", if_id_pc, 32'h0);
    chk("arst.pc4", if_id_pc_plus_4, 32'h0);
    chk("arst.ins", if_id_instruction, NOP);
    chk("arst.v", {31'd0, if_id_valid}, 32'h0);
    chk("arst.flt", {31'd0, misaligned_fault}, 32'h0);
    step();
    chk("arst2.addr", imem_addr, 32'h0);
    stall = 1'b0;
    next_pc_selector = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post.addr", imem_addr, 32'h4);
    chk_ifid("post", 32'h0, 32'hDEAD_0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-003 Port: clk  input  1  rising-edge clock, the only clock.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: stall  input  1  hazard-unit hold of PC and IF/ID register.
REQ-006 Port: flush  input  1  hazard-unit squash of the IF/ID register.
REQ-007 Port: next_pc_selector  input  2  00 sequential, 01 branch target, 10 jalr target, 11 sequential.
REQ-008 Port: branch_target  input  32  PC-relative branch/jal target from EX.
REQ-009 Port: jalr_target  input  32  register-relative jalr target from EX.
REQ-010 Port: imem_addr  output  32  instruction memory address, combinational copy of the PC.
REQ-011 Port: imem_rdata  input  32  instruction word, combinational read of imem_addr.
REQ-012 Port: if_id_pc  output  32  registered PC of the instruction in ID.
REQ-013 Port: if_id_pc_plus_4  output  32  registered PC+4 of the instruction in ID.
REQ-014 Port: if_id_instruction  output  32  registered instruction word in ID.
REQ-015 Port: if_id_valid  output  1  1 = ID holds a real instruction, 0 = bubble.
REQ-016 Port: opcode  output  7  if_id_instruction[6:0], combinational, drives the decoder.
REQ-017 Port: misaligned_fault  output  1  sticky flag, redirect target not word-aligned.

Function
REQ-018 The PC register shall be 32 bits; PC+4 shall wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 Redirect shall be next_pc_selector = 01 or 10; the target shall be branch_target (01) or {jalr_target[31:1],1'b0} (10).
REQ-020 PC update each edge, in priority: redirect -> {target[31:2],2'b00}; else stall -> hold; else PC+4.
REQ-021 A redirect shall take effect even when stall is asserted in the same cycle.
REQ-022 IF/ID update each edge, in priority: flush -> pc/pc+4 unchanged, instruction = NOP_INSTR, valid = 0; else stall -> hold all fields; else load {PC, PC+4, imem_rdata, 1}.
REQ-023 flush shall override stall for the IF/ID register.
REQ-024 Latency: an instruction fetched at PC in cycle N shall appear on if_id_* in cycle N+1.
REQ-025 flush and redirect in the same cycle: IF/ID becomes a bubble and the PC loads the target; the next cycle fetches from the target.
REQ-026 misaligned_fault shall set on any redirect whose target (after jalr bit-0 clear) has bit 1 set; it stays set until reset and never blocks fetch.
REQ-027 opcode shall equal if_id_instruction[6:0] at all times, including bubbles (7'b0010011).
REQ-028 Stall held for any number of cycles shall leave PC and IF/ID bit-identical throughout.

Reset
REQ-029 While rst = 1, asynchronously and independent of clk: PC = RESET_PC, if_id_pc = 0, if_id_pc_plus_4 = 0, if_id_instruction = NOP_INSTR, if_id_valid = 0, misaligned_fault = 0.
REQ-030 The first rising edge after rst deasserts shall load IF/ID from RESET_PC and advance PC to RESET_PC+4.
REQ-031 Reset asserted mid-stall or mid-redirect shall discard the pending operation.

Verification
REQ-032 Reset, then 3 free-running cycles with imem_rdata = PC-derived pattern: imem_addr 0,4,8,C; if_id_pc lags by one cycle; valid = 1.
REQ-033 At PC = 0x10, stall for 3 cycles: imem_addr holds 0x10; if_id_* unchanged; release gives 0x14.
REQ-034 At PC = 0x20, selector = 01 with branch_target = 0x100 and flush = 1: next if_id_valid = 0, instruction = 0x00000013, opcode = 0x13; imem_addr = 0x100.
REQ-035 Selector = 10 with jalr_target = 0x203 and stall = 1: imem_addr = 0x200; misaligned_fault = 1 and stays 1 after later aligned redirects.
REQ-036 Run to PC = 0xFFFF_FFFC, then 1 free cycle: imem_addr = 0x0000_0000 and if_id_pc_plus_4 = 0x0000_0000.
REQ-037 Assert rst between clock edges during a stall: outputs take reset values immediately, without waiting for a clock edge.
